// File: rtl/div_unit_pkg.sv
// Shared types and constants for the execute-stage divide unit and its
// iterative unsigned core.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic {
        DIVU = 1'b0,
        DIV  = 1'b1
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Request as captured at acceptance: magnitudes feed the core, the sign
    // bits drive the fix-up, a_orig is the divide-by-zero remainder.
    typedef struct packed {
        div_op_t                op;
        logic [DIV_WIDTH-1:0]   a_mag;
        logic [DIV_WIDTH-1:0]   b_mag;
        logic                   sign_q;
        logic                   sign_r;
        logic [DIV_WIDTH-1:0]   a_orig;
    } div_req_t;

    function automatic logic [DIV_WIDTH-1:0] neg_mod(input logic [DIV_WIDTH-1:0] x);
        return -x;
    endfunction

endpackage

// File: rtl/div_unit_udiv_core.sv
// Radix-2 restoring unsigned divider: one quotient bit per cycle, ITERS cycles.
// Operands must stay stable on a_i/b_i while busy_o is high.
module udiv_core #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 kill_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int CNT_W = $clog2(ITERS);

    logic [CNT_W-1:0] cnt_q, cnt_d, bit_idx;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH:0]   trial, diff;
    logic             fits, last;

    // Dividend bits are consumed MSB first straight from the held operand.
    assign bit_idx = CNT_W'(ITERS - 1) - cnt_q;
    assign trial   = {rem_q, a_i[bit_idx]};
    assign diff    = trial - {1'b0, b_i};
    assign fits    = ~diff[WIDTH];
    assign last    = (cnt_q == CNT_W'(ITERS - 1));

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        cnt_d  = cnt_q;
        busy_d = busy_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        if (kill_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = '0;
        end else if (busy_q) begin
            rem_d = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], fits};
            cnt_d = cnt_q + CNT_W'(1);
            if (last) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!resetn) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
        end
    end

    // done_o marks the cycle whose closing edge writes the final quotient bit.
    assign busy_o   = busy_q;
    assign done_o   = busy_q & last;
    assign result_o = {rem_q, quo_q};

endmodule

// File: rtl/div_unit.sv
// Execute-stage DIV/DIVU wrapper: sign handling, divide-by-zero fast path,
// valid/ready result port and flush around the iterative unsigned core.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH  // the request struct is sized by DIV_WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_signed,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_hi,
    output logic [WIDTH-1:0]   resp_lo
);

    div_state_t       state_q, state_d;
    div_req_t         req_q, req_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic             accept, b_zero, a_neg, b_neg, zero_path;
    logic             core_start, core_busy, core_done;
    logic [2*WIDTH-1:0] core_result;
    logic [WIDTH-1:0] core_rem, core_quo;

    assign accept     = req_valid & req_ready;
    assign b_zero     = (req_b == '0);
    assign core_start = accept & ~b_zero;
    assign core_rem   = core_result[2*WIDTH-1:WIDTH];
    assign core_quo   = core_result[WIDTH-1:0];

    always_comb begin
        a_neg        = req_signed & req_a[WIDTH-1];
        b_neg        = req_signed & req_b[WIDTH-1];
        req_d.op     = req_signed ? DIV : DIVU;
        req_d.a_mag  = a_neg ? neg_mod(req_a) : req_a;
        req_d.b_mag  = b_neg ? neg_mod(req_b) : req_b;
        req_d.sign_q = a_neg ^ b_neg;
        req_d.sign_r = a_neg;
        req_d.a_orig = req_a;
    end

    udiv_core #(
        .WIDTH (WIDTH),
        .ITERS (DIV_ITERS)
    ) u_core (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (core_start),
        .kill_i   (flush),
        .a_i      (req_q.a_mag),
        .b_i      (req_q.b_mag),
        .busy_o   (core_busy),
        .done_o   (core_done),
        .result_o (core_result)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept)     state_d = b_zero ? DONE : CALC;
                CALC: if (core_done)  state_d = FIX;
                FIX:                  state_d = DONE;
                DONE: if (resp_ready) state_d = IDLE;
                default:              state_d = IDLE;
            endcase
        end
    end

    // Fix-up: quotient/remainder signs restored with modulo negation, so
    // MIN / -1 wraps to MIN with a zero remainder on its own.
    always_comb begin
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        if (state_q == FIX) begin
            res_lo_d = (req_q.op == DIV && req_q.sign_q) ? neg_mod(core_quo) : core_quo;
            res_hi_d = (req_q.op == DIV && req_q.sign_r) ? neg_mod(core_rem) : core_rem;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            if (accept) req_q <= req_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    // A divide-by-zero result is served from the captured request itself.
    always_comb begin
        req_ready  = (state_q == IDLE) & ~flush & ~core_busy;
        resp_valid = (state_q == DONE);
        zero_path  = resp_valid & (req_q.b_mag == '0);
        resp_hi    = zero_path ? req_q.a_orig : res_hi_q;
        resp_lo    = zero_path ? '1 : res_lo_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomised checks of div_unit against an arithmetic model,
// with a scoreboard comparing every valid response cycle.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn, flush, req_valid, req_ready, req_signed;
    logic        resp_valid, resp_ready;
    logic [31:0] req_a, req_b, resp_hi, resp_lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_signed (req_signed),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hi    (resp_hi),
        .resp_lo    (resp_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // {hi=remainder, lo=quotient} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            qv = q;
            rv = r;
            return {rv[31:0], qv[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Scoreboard: every cycle with resp_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {63'd0, resp_valid}, 64'd0);
            end else begin
                check("resp", {resp_hi, resp_lo}, exp_q[0]);
                if (resp_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_signed = sgn; req_a = a; req_b = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(model(sgn, a, b));
                ok = 1'b1;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("accept", {63'd0, ok}, 64'd1);
    endtask

    // Returns the cycle index (T0+n) at which resp_valid is first seen.
    task automatic wait_resp(output int lat, output int rr_high);
        lat = 0; rr_high = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (req_ready) rr_high++;
            if (resp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int lat, rr;
        send(sgn, a, b);
        wait_resp(lat, rr);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_lo"}, resp_lo, exp_lo);
        check({name, "_hi"}, resp_hi, exp_hi);
        check({name, "_rdy_busy"}, rr, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rr, vc;
        logic        sgn;
        logic [31:0] a, b, q, r, mr, mb, recon;

        resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_signed = 1'b0;
        req_a = '0; req_b = '0; resp_ready = 1'b1;

        check("model_divu",  model(1'b0, 32'd100, 32'd7),        {32'd2, 32'd14});
        check("model_div_n", model(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("model_ovf",   model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
        check("model_zero",  model(1'b1, 32'd5, 32'd0),          {32'd5, 32'hFFFF_FFFF});

        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_hi", resp_hi, 0);
        check("rst_lo", resp_lo, 0);

        // Basic latency and ready profile.
        send(1'b0, 32'd100, 32'd7);
        wait_resp(lat, rr);
        check("divu_lat", lat, 34);
        check("divu_lo", resp_lo, 14);
        check("divu_hi", resp_hi, 2);
        check("divu_rdy_busy", rr, 0);
        @(negedge clk);
        check("divu_rdy_after", req_ready, 1);

        run("div_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,          34, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run("div_7_m2",  1'b1, 32'd7,         32'hFFFF_FFFE,  34, 32'hFFFF_FFFD, 32'd1);
        run("div_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  34, 32'h8000_0000, 32'd0);
        run("divu_ovf",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  34, 32'd0,         32'h8000_0000);
        run("div_z",     1'b1, 32'd5,         32'd0,          1,  32'hFFFF_FFFF, 32'd5);
        run("div_z_neg", 1'b1, 32'hFFFF_FFFB, 32'd0,          1,  32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run("divu_z",    1'b0, 32'hDEAD_BEEF, 32'd0,          1,  32'hFFFF_FFFF, 32'hDEAD_BEEF);

        // Backpressure: result held for 10 cycles, then released.
        @(posedge clk); #1 resp_ready = 1'b0;
        send(1'b0, 32'd1000, 32'd33);
        wait_resp(lat, rr);
        check("bp_lat", lat, 34);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", resp_valid, 1);
            check("bp_data", {resp_hi, resp_lo}, {32'd10, 32'd30});
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_rel_valid", resp_valid, 0);
        check("bp_rel_ready", req_ready, 1);

        // Flush during CALC at T0+10.
        send(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_rdy_masked", req_ready, 0);
        @(posedge clk); #1 flush = 1'b0; exp_q.delete();
        @(negedge clk);
        check("flush_rdy_t11", req_ready, 1);
        vc = 0;
        repeat (40) @(negedge clk) if (resp_valid) vc++;
        check("flush_no_resp", vc, 0);

        // Flush coinciding with a response handshake in DONE.
        @(posedge clk); #1 resp_ready = 1'b0;
        send(1'b0, 32'd50, 32'd5);
        wait_resp(lat, rr);
        check("fd_lat", lat, 34);
        @(posedge clk); #1 flush = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 flush = 1'b0; exp_q.delete();
        @(negedge clk);
        check("fd_valid", resp_valid, 0);
        check("fd_ready", req_ready, 1);

        // Flush beats a simultaneous request in IDLE.
        @(posedge clk); #1 flush = 1'b1; req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd1; req_b = 32'd1;
        @(negedge clk);
        check("fr_rdy_masked", req_ready, 0);
        @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("fr_not_taken", req_ready, 1);
        vc = 0;
        repeat (40) @(negedge clk) if (resp_valid) vc++;
        check("fr_no_resp", vc, 0);

        // Asynchronous reset mid-operation at T0+20.
        send(1'b0, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #1 resetn = 1'b0; exp_q.delete();
        #1;
        check("arst_valid", resp_valid, 0);
        check("arst_hi", resp_hi, 0);
        check("arst_lo", resp_lo, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("arst_ready", req_ready, 1);
        vc = 0;
        repeat (40) @(negedge clk) if (resp_valid) vc++;
        check("arst_no_resp", vc, 0);
        run("post_rst", 1'b0, 32'd9, 32'd3, 34, 32'd3, 32'd0);

        // Random regression with corner operands; invariants on each result.
        for (int k = 0; k < 300; k++) begin
            sgn = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            send(sgn, a, b);
            wait_resp(lat, rr);
            check("rnd_lat", lat, (b == 32'd0) ? 1 : 34);
            q = resp_lo;
            r = resp_hi;
            if (b != 32'd0) begin
                recon = q * b + r;
                check("inv_eq", recon, a);
                if (sgn) begin
                    mr = r[31] ? -r : r;
                    mb = b[31] ? -b : b;
                    check("inv_rmag", {63'd0, mr < mb}, 64'd1);
                    check("inv_rsign", {63'd0, (r == 32'd0) || (r[31] == a[31])}, 64'd1);
                end else begin
                    check("inv_rmag_u", {63'd0, r < b}, 64'd1);
                end
            end
        end
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
